// File: rtl/i2c_eeprom_core.sv
// I2C EEPROM behind AXI-stream byte ports: [addr hi][addr lo] data... writes, IDLE streams mem[ptr]; optional wp port via EEPROM_WP_EN.
// Zero-latency reads and same-edge writes; m_axis never stalls, s_axis is offered only in IDLE with no write beat pending.
module i2c_eeprom_core #(
  parameter int ADDR_BYTES   = 2,
  parameter int MEM_DEPTH    = 2048,
  parameter int PAGE_SIZE    = 16,
  parameter int WRITE_CYCLES = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] m_axis_tdata,
  input  logic       m_axis_tvalid,
  input  logic       m_axis_tlast,
  output logic       m_axis_tready,
  output logic [7:0] s_axis_tdata,
  output logic       s_axis_tvalid,
  input  logic       s_axis_tready,
  output logic       s_axis_tlast,
  output logic       enable,
  output logic       busy
`ifdef EEPROM_WP_EN
  ,
  input  logic       wp
`endif
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = $clog2(WRITE_CYCLES + 2);
  localparam logic [AW-1:0] PAGE_MASK = AW'(PAGE_SIZE - 1);
  localparam logic [CW-1:0] WC_LAST   = CW'((WRITE_CYCLES > 0) ? WRITE_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, ADDR, WRITE, WCYCLE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [7:0]    addr_q, addr_d;
  logic [1:0]    acnt_q, acnt_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          wrote_q, wrote_d;
  logic          mem_we;
  logic          wp_on;
  logic [7:0]    mem [MEM_DEPTH];

`ifdef EEPROM_WP_EN
  assign wp_on = wp;
`else
  assign wp_on = 1'b0;
`endif

  assign m_axis_tready = 1'b1;
  assign s_axis_tlast  = 1'b0;
  assign s_axis_tdata  = mem[ptr_q];

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    addr_d        = addr_q;
    acnt_d        = acnt_q;
    wcnt_d        = wcnt_q;
    wrote_d       = wrote_q;
    mem_we        = 1'b0;
    s_axis_tvalid = 1'b0;
    enable        = 1'b1;
    busy          = 1'b0;
    case (state_q)
      IDLE: begin
        s_axis_tvalid = !m_axis_tvalid;
        wrote_d       = 1'b0;
        wcnt_d        = '0;
        if (m_axis_tvalid) begin
          addr_d = m_axis_tdata;
          acnt_d = 2'd1;
          // A lone address byte with tlast still becomes the read pointer.
          if (ADDR_BYTES == 1 || m_axis_tlast) ptr_d = AW'(m_axis_tdata);
          if (m_axis_tlast)         state_d = IDLE;
          else if (ADDR_BYTES == 1) state_d = WRITE;
          else                      state_d = ADDR;
        end else if (s_axis_tready) begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      ADDR: begin
        if (m_axis_tvalid) begin
          addr_d = m_axis_tdata;
          acnt_d = acnt_q + 1'b1;
          if (acnt_q == 2'(ADDR_BYTES - 1) || m_axis_tlast) begin
            ptr_d   = AW'({addr_q, m_axis_tdata});
            state_d = m_axis_tlast ? IDLE : WRITE;
          end
        end
      end
      WRITE: begin
        if (m_axis_tvalid) begin
          mem_we  = !wp_on;
          wrote_d = 1'b1;
          // Sequential writes stay inside the current page.
          ptr_d   = (ptr_q & ~PAGE_MASK) | ((ptr_q + 1'b1) & PAGE_MASK);
          if (m_axis_tlast) begin
            wcnt_d  = '0;
            state_d = (WRITE_CYCLES > 0 && wrote_d && !wp_on) ? WCYCLE : IDLE;
          end
        end
      end
      WCYCLE: begin
        enable = 1'b0;
        busy   = 1'b1;
        wcnt_d = wcnt_q + 1'b1;
        if (wcnt_q == WC_LAST) begin
          wcnt_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      addr_q  <= '0;
      acnt_q  <= '0;
      wcnt_q  <= '0;
      wrote_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      acnt_q  <= acnt_d;
      wcnt_q  <= wcnt_d;
      wrote_q <= wrote_d;
    end
  end

  // Array has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[ptr_q] <= m_axis_tdata;
  end

endmodule

// File: tb/tb_i2c_eeprom_core.sv
// Bench for i2c_eeprom_core: vector table, directed corner sequences, random transactions vs a memory model.
module tb_i2c_eeprom_core;

  localparam int WC = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] m_tdata;
  logic       m_tvalid, m_tlast, m_tready;
  logic [7:0] s_tdata;
  logic       s_tvalid, s_tready, s_tlast;
  logic       enable, busy;
`ifdef EEPROM_WP_EN
  logic       wp;
`endif

  i2c_eeprom_core dut (
    .clk(clk), .rst(rst),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .enable(enable), .busy(busy)
`ifdef EEPROM_WP_EN
    , .wp(wp)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] ref_mem [2048];
  bit         ref_ok  [2048];
  int         ref_ptr;
  logic [7:0] wb [32];
  int         last_wr;

  typedef struct {
    logic       mv;
    logic [7:0] d;
    logic       l;
    logic       sr;
    logic       svld;
    logic [7:0] sdat;
    logic       chkd;
    logic       en;
    logic       bsy;
  } vec_t;
  vec_t tbl [10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic mv, input logic [7:0] d, input logic l, input logic sr);
    m_tvalid = mv; m_tdata = d; m_tlast = l; s_tready = sr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat_chk(input logic [7:0] d, input logic l, input string nm);
    drive(1'b1, d, l, 1'($urandom_range(0, 1)));
    check({nm, " s_tvalid on write beat"}, s_tvalid, 0);
    check({nm, " enable on write beat"}, enable, 1);
    tick();
  endtask

  task automatic wait_wc(input int exp_cycles, input string nm);
    int n = 0;
    int en_bad = 0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    while (busy && n < 300) begin
      if (enable) en_bad++;
      n++;
      tick();
    end
    check({nm, " write-cycle length"}, n, exp_cycles);
    check({nm, " enable high during write cycle"}, en_bad, 0);
    check({nm, " enable after write cycle"}, enable, 1);
  endtask

  task automatic wr_txn(input logic [15:0] addr, input int n, input bit prot, input bit do_wait, input string nm);
    int a, base, loc;
    a = int'(addr) & 'h7FF;
    base = a & ~15;
`ifdef EEPROM_WP_EN
    wp = prot;
`endif
    beat_chk(addr[15:8], 1'b0, nm);
    beat_chk(addr[7:0], 1'b0, nm);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        check({nm, " s_tvalid in data gap"}, s_tvalid, 0);
        tick();
      end
      beat_chk(wb[i], 1'(i == n - 1), nm);
      loc = base | ((a + i) & 15);
      if (!prot) begin
        ref_mem[loc] = wb[i];
        ref_ok[loc] = 1'b1;
      end
    end
    ref_ptr = base | ((a + n) & 15);
    if (do_wait) wait_wc(prot ? 0 : WC, nm);
`ifdef EEPROM_WP_EN
    wp = 1'b0;
`endif
  endtask

  task automatic set_addr(input logic [15:0] addr, input string nm);
    beat_chk(addr[15:8], 1'b0, nm);
    beat_chk(addr[7:0], 1'b1, nm);
    ref_ptr = int'(addr) & 'h7FF;
  endtask

  task automatic rd(input logic sr, input int want, input string nm);
    drive(1'b0, 8'h00, 1'b0, sr);
    check({nm, " s_tvalid"}, s_tvalid, 1);
    if (want >= 0) check({nm, " data"}, s_tdata, want);
    else if (ref_ok[ref_ptr]) check({nm, " data vs model"}, s_tdata, ref_mem[ref_ptr]);
    tick();
    if (sr) ref_ptr = (ref_ptr + 1) & 'h7FF;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 2048; i++) begin ref_ok[i] = 1'b0; ref_mem[i] = 8'h00; end
    ref_ptr = 0;
    last_wr = 0;
`ifdef EEPROM_WP_EN
    wp = 1'b0;
`endif
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("reset busy", busy, 0);
    check("reset enable", enable, 1);
    check("reset s_tvalid", s_tvalid, 1);
    check("reset m_tready", m_tready, 1);
    check("reset s_tlast", s_tlast, 0);

    wb[0] = 8'hEE;
    wr_txn(16'h0125, 1, 1'b0, 1'b1, "pre125");

    // mv d l sr | svld sdat chkd en bsy
    tbl[0] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 8'h23, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 8'hBB, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 8'h23, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hAA, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hBB, 1'b1, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hEE, 1'b1, 1'b1, 1'b0};
    for (int r = 0; r < 10; r++) begin
      drive(tbl[r].mv, tbl[r].d, tbl[r].l, tbl[r].sr);
      check($sformatf("vec%0d s_tvalid", r), s_tvalid, tbl[r].svld);
      check($sformatf("vec%0d enable", r), enable, tbl[r].en);
      check($sformatf("vec%0d busy", r), busy, tbl[r].bsy);
      if (tbl[r].chkd) check($sformatf("vec%0d s_tdata", r), s_tdata, tbl[r].sdat);
      tick();
      if (r == 3) begin
        check("req050 busy first wcycle clock", busy, 1);
        wait_wc(WC, "req050");
      end
    end
    ref_mem['h123] = 8'hAA; ref_ok['h123] = 1'b1;
    ref_mem['h124] = 8'hBB; ref_ok['h124] = 1'b1;
    ref_ptr = 'h125;

    wb[0] = 8'h11; wb[1] = 8'h22; wb[2] = 8'h33;
    wr_txn(16'h07FE, 3, 1'b0, 1'b1, "req052");
    wb[0] = 8'hC0;
    wr_txn(16'h0000, 1, 1'b0, 1'b1, "zero");
    set_addr(16'h07FE, "req052 sa");
    rd(1'b1, 'h11, "req052 7FE");
    rd(1'b1, 'h22, "req052 7FF");
    set_addr(16'hF7F0, "req052 sa2");
    rd(1'b1, 'h33, "req052 7F0 wrap");
    set_addr(16'h07FF, "req053 sa");
    rd(1'b1, 'h22, "req053 7FF");
    rd(1'b1, 'hC0, "req053 000 wrap");

    wb[0] = 8'h5A; wb[1] = 8'h5B;
    wr_txn(16'h0000, 2, 1'b0, 1'b0, "req054");
    check("req054 busy wcycle clock 1", busy, 1);
    repeat (4) tick();
    drive(1'b1, 8'h77, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (14) tick();
    check("req054 busy wcycle clock 20", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("req054 busy after rst", busy, 0);
    check("req054 enable after rst", enable, 1);
    ref_ptr = 0;
    rd(1'b1, 'h5A, "req054 ptr0 data");
    rd(1'b1, 'h5B, "req054 retained");

`ifdef EEPROM_WP_EN
    wb[0] = 8'h99; wb[1] = 8'h98;
    wr_txn(16'h0010, 2, 1'b0, 1'b1, "wp prep");
    wb[0] = 8'h55;
    wr_txn(16'h0010, 1, 1'b1, 1'b1, "req055");
    rd(1'b1, 'h98, "req055 ptr advanced");
    set_addr(16'h0010, "req055 sa");
    rd(1'b1, 'h99, "req055 mem unchanged");
`endif

    for (int it = 0; it < 40; it++) begin
      int kind, n, nr;
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        n = $urandom_range(1, 20);
        for (int i = 0; i < n; i++) wb[i] = 8'($urandom);
        last_wr = $urandom_range(0, 65535);
        wr_txn(16'(last_wr), n, 1'b0, 1'b1, "rnd wr");
      end else begin
        if (kind == 1) begin
          if ($urandom_range(0, 1) == 1) set_addr(16'(last_wr), "rnd sa");
          else set_addr(16'($urandom), "rnd sa");
        end
        nr = $urandom_range(1, 6);
        for (int k = 0; k < nr; k++) rd(1'($urandom_range(0, 1)), -1, "rnd rd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_eeprom_core.md
I2C_EEPROM_CORE -- requirements
Module: i2c_eeprom_core

Interface
REQ-001 Parameters SHALL be:
- ADDR_BYTES, default 2: word-address bytes per write transaction, legal values 1 or 2.
- MEM_DEPTH, default 2048: memory size in bytes, a power of two, at most 256^ADDR_BYTES.
- PAGE_SIZE, default 16: page size in bytes, a power of two, at most MEM_DEPTH.
- WRITE_CYCLES, default 100: internal write-cycle duration in clk cycles; 0 disables the write cycle.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock.
- rst, in, 1: synchronous active-high reset.
- m_axis_tdata, in, 8: byte written by the bus master, from the I2C slave.
- m_axis_tvalid, in, 1: write byte valid.
- m_axis_tlast, in, 1: last byte before STOP.
- m_axis_tready, out, 1: write byte accept.
- s_axis_tdata, out, 8: read byte to the I2C slave.
- s_axis_tvalid, out, 1: read byte valid.
- s_axis_tready, in, 1: read byte taken.
- s_axis_tlast, out, 1: always 0.
- enable, out, 1: I2C slave enable; 0 makes the device NACK its address.
- busy, out, 1: internal write cycle in progress.
- wp, in, 1: write protect; present only with EEPROM_WP_EN.

REQ-003 Clock and reset SHALL be one clock, clk, with reset rst synchronous and active-high.

Function
REQ-010 States SHALL be IDLE, ADDR, WRITE and WCYCLE.
REQ-011 Internal registers SHALL be: word pointer ptr of width log2(MEM_DEPTH); address byte counter; write-cycle counter; and wrote_flag, which records that a data byte arrived in this transaction.
REQ-012 m_axis_tready SHALL be 1 in every state.
REQ-013 In IDLE, an m_axis beat SHALL load the first address byte and move to ADDR, or to WRITE when ADDR_BYTES=1.
REQ-014 Address bytes SHALL be big-endian; bits above log2(MEM_DEPTH) SHALL be discarded; ptr SHALL be updated only after the final address byte.
REQ-015 A tlast on any address byte SHALL latch the bytes received so far and return to IDLE with no write and no write cycle (random-read address set).
REQ-016 In WRITE, each m_axis beat SHALL write mem[ptr] in the same clock edge and set wrote_flag.
- ptr SHALL then increment within its page only: low log2(PAGE_SIZE) bits wrap, upper bits are held.
- Overflowing a page SHALL therefore overwrite from the page start.
REQ-017 A tlast in WRITE SHALL go to WCYCLE when WRITE_CYCLES>0, otherwise to IDLE.
REQ-018 WCYCLE SHALL hold busy=1 and enable=0 for exactly WRITE_CYCLES clocks, counted from the cycle after tlast, then return to IDLE with enable=1.
REQ-019 m_axis beats arriving in WCYCLE SHALL be accepted and discarded.
REQ-020 In IDLE, s_axis_tvalid SHALL be 1 and s_axis_tdata SHALL be mem[ptr] combinationally.
REQ-021 Each s_axis handshake SHALL increment ptr modulo MEM_DEPTH: reads roll over the whole array, not the page.
REQ-022 s_axis_tvalid SHALL be 0 in ADDR, WRITE and WCYCLE, and 0 in any IDLE cycle where m_axis_tvalid=1; in that simultaneous case the write path wins.
REQ-023 ptr SHALL persist across transactions, giving current-address read semantics.
REQ-024 enable SHALL be 1 and busy 0 in every state except WCYCLE.

Reset
REQ-030 rst SHALL set state=IDLE, ptr=0, wrote_flag=0, the write-cycle counter to 0, enable=1 and busy=0.
REQ-031 rst SHALL leave memory contents unchanged.
REQ-032 rst asserted mid-write or mid-WCYCLE SHALL abort immediately; bytes already written SHALL remain.

Configuration
REQ-040 Macro EEPROM_WP_EN defined:
- The wp port SHALL exist.
- When wp=1 in WRITE, data beats SHALL be accepted but memory SHALL be unchanged.
- ptr SHALL still advance per REQ-016.
- tlast SHALL return to IDLE with no WCYCLE.
REQ-041 Macro EEPROM_WP_EN undefined: there SHALL be no wp port, and writes SHALL always proceed.

Verification (ADDR_BYTES=2, MEM_DEPTH=2048, PAGE_SIZE=16, WRITE_CYCLES=100)
REQ-050 Write 0x01,0x23,0xAA,0xBB(last) -> mem[0x123]=0xAA and mem[0x124]=0xBB; busy=1 and enable=0 for exactly 100 clocks.
REQ-051 Set address 0x01,0x23(last), then two reads -> 0xAA then 0xBB; ptr=0x125.
REQ-052 Write address 0x07,0xFE plus data 0x11,0x22,0x33(last) -> mem[0x7FE]=0x11, mem[0x7FF]=0x22, mem[0x7F0]=0x33 (page wrap).
REQ-053 Set address 0x07FF, then two reads -> mem[0x7FF] then mem[0x000] (full-array wrap).
REQ-054 Assert rst on the 20th clock of WCYCLE -> next cycle busy=0, enable=1, ptr=0; written data retained.
REQ-055 With EEPROM_WP_EN and wp=1, write 0x00,0x10,0x55(last) -> mem[0x010] unchanged and busy never asserted.
